// File: rtl/bp_common_cfg_pkg.sv
// Shared config-bus constants, CCE mode encoding and loader state encoding.
package bp_common_cfg_pkg;

  localparam logic [15:0] FREEZE     = 16'h0001;
  localparam logic [15:0] CORE_ID    = 16'h0002;
  localparam logic [15:0] ICACHE_ID  = 16'h0003;
  localparam logic [15:0] DCACHE_ID  = 16'h0004;
  localparam logic [15:0] CCE_ID     = 16'h0005;
  localparam logic [15:0] CCE_MODE   = 16'h0006;
  localparam logic [15:0] UCODE_BASE = 16'h8000;

  typedef enum logic {
    e_cce_mode_uncached = 1'b0,
    e_cce_mode_normal   = 1'b1
  } bp_cce_mode_e;

  typedef enum logic [3:0] {
    e_reset         = 4'd0,
    e_freeze        = 4'd1,
    e_core_id       = 4'd2,
    e_icache_id     = 4'd3,
    e_dcache_id     = 4'd4,
    e_cce_id        = 4'd5,
    e_cce_mode_unc  = 4'd6,
    e_ucode_fetch   = 4'd7,
    e_ucode_send    = 4'd8,
    e_cce_mode_norm = 4'd9,
    e_unfreeze      = 4'd10,
    e_done          = 4'd11
  } bp_cfg_loader_state_e;

  // Width of a counter indexing n items; never below one bit.
  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bp_cfg_loader_counter.sv
// Clear/increment counter with a terminal-count flag.
module bp_cfg_loader_counter #(
  parameter int unsigned width_p = 8,
  parameter int unsigned limit_p = 255
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic               incr_i,
  output logic [width_p-1:0] count_o,
  output logic               last_o
);

  logic [width_p-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (incr_i) begin
      count_d = count_q + width_p'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign last_o  = (count_q == width_p'(limit_p));

endmodule

// File: rtl/bp_cfg_loader.sv
// Post-reset config sequencer: freezes, IDs, loads CCE microcode and releases each tile in turn.
// Optional stall counter output is enabled by defining BP_CFG_LOADER_STATS_EN.
module bp_cfg_loader
  import bp_common_cfg_pkg::*;
#(
  parameter int unsigned num_core_p              = 1,
  parameter int unsigned num_lce_p               = 2,
  parameter int unsigned num_cce_instr_ram_els_p = 256,
  parameter int unsigned cfg_addr_width_p        = 16,
  parameter int unsigned cfg_data_width_p        = 64
) (
  input  logic                                             clk_i,
  input  logic                                             reset_n_i,
  output logic                                             cfg_v_o,
  input  logic                                             cfg_ready_i,
  output logic [safe_clog2(num_core_p)-1:0]                cfg_core_o,
  output logic [cfg_addr_width_p-1:0]                      cfg_addr_o,
  output logic [cfg_data_width_p-1:0]                      cfg_data_o,
  output logic                                             rom_v_o,
  output logic [safe_clog2(num_cce_instr_ram_els_p)-1:0]   rom_addr_o,
  input  logic [cfg_data_width_p-1:0]                      rom_data_i,
  output logic                                             done_o
`ifdef BP_CFG_LOADER_STATS_EN
  ,
  output logic [31:0]                                      stall_cnt_o
`endif
);

  localparam int unsigned core_w_lp  = safe_clog2(num_core_p);
  localparam int unsigned instr_w_lp = safe_clog2(num_cce_instr_ram_els_p);

  if (num_lce_p != 2 * num_core_p) begin : g_bad_lce
    $error("num_lce_p must equal 2*num_core_p");
  end

  bp_cfg_loader_state_e state_q, state_d;

  logic [core_w_lp-1:0]  core_cnt;
  logic [instr_w_lp-1:0] instr_cnt;
  logic                  core_last, instr_last;
  logic                  core_incr, instr_incr, instr_clr;
  logic [cfg_data_width_p-1:0] core_ext;

  bp_cfg_loader_counter #(
    .width_p (core_w_lp),
    .limit_p (num_core_p - 1)
  ) u_core_cnt (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (1'b0),
    .incr_i    (core_incr),
    .count_o   (core_cnt),
    .last_o    (core_last)
  );

  bp_cfg_loader_counter #(
    .width_p (instr_w_lp),
    .limit_p (num_cce_instr_ram_els_p - 1)
  ) u_instr_cnt (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (instr_clr),
    .incr_i    (instr_incr),
    .count_o   (instr_cnt),
    .last_o    (instr_last)
  );

  assign core_ext   = cfg_data_width_p'(core_cnt);
  assign cfg_core_o = core_cnt;

  // Write states advance only on cfg_ready_i; cfg_v_o is implied high there.
  always_comb begin
    state_d    = state_q;
    cfg_v_o    = 1'b0;
    rom_v_o    = 1'b0;
    done_o     = 1'b0;
    cfg_addr_o = '0;
    cfg_data_o = '0;
    rom_addr_o = '0;
    core_incr  = 1'b0;
    instr_incr = 1'b0;
    instr_clr  = 1'b0;
    case (state_q)
      e_reset: state_d = e_freeze;
      e_freeze: begin
        cfg_v_o    = 1'b1;
        cfg_addr_o = cfg_addr_width_p'(FREEZE);
        cfg_data_o = cfg_data_width_p'(1);
        if (cfg_ready_i) state_d = e_core_id;
      end
      e_core_id: begin
        cfg_v_o    = 1'b1;
        cfg_addr_o = cfg_addr_width_p'(CORE_ID);
        cfg_data_o = core_ext;
        if (cfg_ready_i) state_d = e_icache_id;
      end
      e_icache_id: begin
        cfg_v_o    = 1'b1;
        cfg_addr_o = cfg_addr_width_p'(ICACHE_ID);
        cfg_data_o = core_ext << 1;
        if (cfg_ready_i) state_d = e_dcache_id;
      end
      e_dcache_id: begin
        cfg_v_o    = 1'b1;
        cfg_addr_o = cfg_addr_width_p'(DCACHE_ID);
        cfg_data_o = (core_ext << 1) | cfg_data_width_p'(1);
        if (cfg_ready_i) state_d = e_cce_id;
      end
      e_cce_id: begin
        cfg_v_o    = 1'b1;
        cfg_addr_o = cfg_addr_width_p'(CCE_ID);
        cfg_data_o = core_ext;
        if (cfg_ready_i) state_d = e_cce_mode_unc;
      end
      e_cce_mode_unc: begin
        cfg_v_o    = 1'b1;
        cfg_addr_o = cfg_addr_width_p'(CCE_MODE);
        cfg_data_o = cfg_data_width_p'(e_cce_mode_uncached);
        if (cfg_ready_i) state_d = e_ucode_fetch;
      end
      e_ucode_fetch: begin
        rom_v_o    = 1'b1;
        rom_addr_o = instr_cnt;
        state_d    = e_ucode_send;
      end
      e_ucode_send: begin
        cfg_v_o    = 1'b1;
        cfg_addr_o = cfg_addr_width_p'(UCODE_BASE) + cfg_addr_width_p'(instr_cnt);
        cfg_data_o = rom_data_i;
        if (cfg_ready_i) begin
          if (instr_last) begin
            instr_clr = 1'b1;
            state_d   = e_cce_mode_norm;
          end else begin
            instr_incr = 1'b1;
            state_d    = e_ucode_fetch;
          end
        end
      end
      e_cce_mode_norm: begin
        cfg_v_o    = 1'b1;
        cfg_addr_o = cfg_addr_width_p'(CCE_MODE);
        cfg_data_o = cfg_data_width_p'(e_cce_mode_normal);
        if (cfg_ready_i) state_d = e_unfreeze;
      end
      e_unfreeze: begin
        cfg_v_o    = 1'b1;
        cfg_addr_o = cfg_addr_width_p'(FREEZE);
        cfg_data_o = '0;
        if (cfg_ready_i) begin
          if (core_last) begin
            state_d = e_done;
          end else begin
            core_incr = 1'b1;
            state_d   = e_freeze;
          end
        end
      end
      e_done: done_o = 1'b1;
      default: state_d = e_reset;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= e_reset;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef BP_CFG_LOADER_STATS_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      stall_cnt_q <= '0;
    end else if (cfg_v_o && !cfg_ready_i && !done_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  // Stall accounting compiled out; bus behaviour is unchanged.
`endif

endmodule

// File: tb/tb_bp_cfg_loader.sv
// Randomized bench for bp_cfg_loader against a queue-based model of the expected write program.
module tb_bp_cfg_loader;
  import bp_common_cfg_pkg::*;

  localparam int unsigned NumCore = 2;
  localparam int unsigned Els     = 4;
  localparam int unsigned AddrW   = 16;
  localparam int unsigned DataW   = 64;
  localparam int unsigned CoreW   = safe_clog2(NumCore);
  localparam int unsigned InstrW  = safe_clog2(Els);
  localparam int          Budget  = 3000;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              cfg_v, cfg_ready, rom_v, done;
  logic [CoreW-1:0]  cfg_core;
  logic [AddrW-1:0]  cfg_addr;
  logic [DataW-1:0]  cfg_data;
  logic [InstrW-1:0] rom_addr;
  logic [DataW-1:0]  rom_data;
  logic [DataW-1:0]  rom_q;
  logic [DataW-1:0]  rom_mem [Els];
`ifdef BP_CFG_LOADER_STATS_EN
  logic [31:0]       stall_cnt;
`endif

  always #5 clk = ~clk;

  // Synchronous ROM: one-cycle latency, data held until the next strobe.
  always @(posedge clk) if (rom_v) rom_q <= rom_mem[rom_addr];
  assign rom_data = rom_q;

  bp_cfg_loader #(
    .num_core_p              (NumCore),
    .num_lce_p               (2 * NumCore),
    .num_cce_instr_ram_els_p (Els),
    .cfg_addr_width_p        (AddrW),
    .cfg_data_width_p        (DataW)
  ) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .cfg_v_o     (cfg_v),
    .cfg_ready_i (cfg_ready),
    .cfg_core_o  (cfg_core),
    .cfg_addr_o  (cfg_addr),
    .cfg_data_o  (cfg_data),
    .rom_v_o     (rom_v),
    .rom_addr_o  (rom_addr),
    .rom_data_i  (rom_data),
    .done_o      (done)
`ifdef BP_CFG_LOADER_STATS_EN
    ,
    .stall_cnt_o (stall_cnt)
`endif
  );

  int tests = 0;
  int fails = 0;

  int unsigned       exp_core [$];
  logic [15:0]       exp_addr [$];
  logic [DataW-1:0]  exp_data [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_wr(input int unsigned c, input logic [15:0] a, input logic [63:0] d);
    exp_core.push_back(c);
    exp_addr.push_back(a);
    exp_data.push_back(d);
  endtask

  // Fresh ROM image and the full write program it implies.
  task automatic new_program();
    for (int i = 0; i < int'(Els); i++) rom_mem[i] = {$urandom, $urandom};
    exp_core.delete();
    exp_addr.delete();
    exp_data.delete();
    for (int unsigned c = 0; c < NumCore; c++) begin
      push_wr(c, 16'h0001, 64'd1);
      push_wr(c, 16'h0002, 64'(c));
      push_wr(c, 16'h0003, 64'(2 * c));
      push_wr(c, 16'h0004, 64'(2 * c + 1));
      push_wr(c, 16'h0005, 64'(c));
      push_wr(c, 16'h0006, 64'd0);
      for (int unsigned i = 0; i < Els; i++) push_wr(c, 16'h8000 + 16'(i), rom_mem[i]);
      push_wr(c, 16'h0006, 64'd1);
      push_wr(c, 16'h0001, 64'd0);
    end
  endtask

  task automatic check_zero(input string pre);
    check_eq({pre, "_flags"}, 64'({cfg_v, rom_v, done}), 64'd0);
    check_eq({pre, "_core"}, 64'(cfg_core), 64'd0);
    check_eq({pre, "_addr"}, 64'(cfg_addr), 64'd0);
    check_eq({pre, "_data"}, cfg_data, 64'd0);
    check_eq({pre, "_romaddr"}, 64'(rom_addr), 64'd0);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    cfg_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
  endtask

  // Entered just after a clock edge with reset low; releases reset and drives the bus
  // until done_o, or until the abort point when abort is set.
  task automatic run_prog(input int ready_pct, input int stall_n, input bit abort,
                          input bit timing, output bit aborted);
    int idx = 0;
    int cyc = 0;
    int done_cyc = 0;
    int stall_left = stall_n;
    bit prev_st = 1'b0;
    logic [CoreW-1:0] p_core;
    logic [AddrW-1:0] p_addr;
    logic [DataW-1:0] p_data;
    aborted   = 1'b0;
    reset_n   = 1'b1;
    cfg_ready = ($urandom_range(99) < ready_pct);
    while (cyc < Budget && done_cyc == 0) begin
      @(negedge clk);
      cyc++;
      if (prev_st) begin
        check_eq("hold_v", 64'(cfg_v), 64'd1);
        check_eq("hold_core", 64'(cfg_core), 64'(p_core));
        check_eq("hold_addr", 64'(cfg_addr), 64'(p_addr));
        check_eq("hold_data", cfg_data, p_data);
      end
      prev_st = cfg_v && !cfg_ready;
      p_core  = cfg_core;
      p_addr  = cfg_addr;
      p_data  = cfg_data;
      if (abort && cfg_v && cfg_core == '0 && cfg_addr == 16'h8002) begin
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check_zero("abort");
        aborted = 1'b1;
        return;
      end
      if (cfg_v && cfg_ready) begin
        if (idx < exp_addr.size()) begin
          check_eq("wr_core", 64'(cfg_core), 64'(exp_core[idx]));
          check_eq("wr_addr", 64'(cfg_addr), 64'(exp_addr[idx]));
          check_eq("wr_data", cfg_data, exp_data[idx]);
        end else begin
          check_eq("extra_hs", 64'(idx), 64'(exp_addr.size()));
        end
        if (stall_n > 0 && idx == 0) begin
          check_eq("stall_hs_cyc", 64'(cyc), 64'(2 + stall_n));
`ifdef BP_CFG_LOADER_STATS_EN
          check_eq("stall_cnt", 64'(stall_cnt), 64'(stall_n));
`endif
        end
        idx++;
      end
      if (done) done_cyc = cyc;
      else begin
        @(posedge clk);
        #1;
        if (stall_left > 0 && cfg_v) begin
          cfg_ready = 1'b0;
          stall_left--;
        end else begin
          cfg_ready = ($urandom_range(99) < ready_pct);
        end
      end
    end
    check_eq("done_seen", 64'(done), 64'd1);
    check_eq("hs_total", 64'(idx), 64'(NumCore * (8 + Els)));
    if (timing) check_eq("done_cyc", 64'(done_cyc), 64'(2 + NumCore * (8 + 2 * Els)));
  endtask

  initial begin
    bit ab;
    reset_n   = 1'b0;
    cfg_ready = 1'b0;

    // Always-ready run, exact timing, then idle after done.
    new_program();
    do_reset();
    run_prog(100, 0, 1'b0, 1'b1, ab);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check_eq("post_done", 64'({cfg_v, rom_v, done}), 64'b001);
    end

    // Backpressured runs with fresh ROM contents.
    for (int r = 0; r < 2; r++) begin
      new_program();
      do_reset();
      run_prog(30, 0, 1'b0, 1'b0, ab);
    end

    // Reset during core 0 microcode word 2, then a clean restart.
    new_program();
    do_reset();
    run_prog(100, 0, 1'b1, 1'b0, ab);
    check_eq("abort_hit", 64'(ab), 64'd1);
    run_prog(100, 0, 1'b0, 1'b0, ab);

    // Long stall on the very first write.
    new_program();
    do_reset();
    run_prog(100, 100, 1'b0, 1'b0, ab);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bp_cfg_loader.md
Name: bp_cfg_loader

Overview:
- Post-reset configuration sequencer for a multicore build.
- For each core it walks a fixed program over the shared config bus:
  - freezes the tile;
  - assigns core, LCE and CCE IDs;
  - loads CCE microcode from an external synchronous ROM;
  - switches the CCE to normal mode;
  - unfreezes the tile.
- It is the single master of the config bus and serialises all tiles. It sits at the top level, next to the memory/host glue.

Parameters:
- num_core_p, 1, cores to configure; 1..16.
- num_lce_p, 2, total LCEs; must equal 2*num_core_p.
- num_cce_instr_ram_els_p, 256, microcode words loaded per CCE.
- cfg_addr_width_p, 16, config register address width.
- cfg_data_width_p, 64, config data width; must be at least the CCE instruction width.

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  synchronous active-low reset
- cfg_v_o  out  1  config write valid
- cfg_ready_i  in  1  config bus accepts this cycle
- cfg_core_o  out  clog2(num_core_p)  destination tile
- cfg_addr_o  out  cfg_addr_width_p  register address
- cfg_data_o  out  cfg_data_width_p  write data
- rom_v_o  out  1  ROM read strobe
- rom_addr_o  out  clog2(num_cce_instr_ram_els_p)  ROM word address
- rom_data_i  in  cfg_data_width_p  ROM data
- done_o  out  1  all cores configured; sticky until reset

Behaviour:
- Reset
  - Reset is sampled on the clk_i edge only.
  - While reset_n_i=0: state=e_reset, core_cnt=0, instr_cnt=0.
  - While reset_n_i=0 all outputs are 0: cfg_v_o, rom_v_o, done_o, cfg_core_o, cfg_addr_o, cfg_data_o and rom_addr_o.
  - The first cycle after reset release moves to e_freeze.
  - A reset asserted mid-program aborts immediately; any in-flight write is dropped and the sequence restarts from core 0.
- Output generation
  - Outputs decode combinationally from registered state only (state, core_cnt, instr_cnt).
  - rom_data_i is the one exception: it feeds cfg_data_o directly in e_ucode_send.
  - cfg_core_o = core_cnt.
- Handshake
  - A write completes on a cycle with cfg_v_o & cfg_ready_i.
  - On any other cycle the state and the values of cfg_core_o, cfg_addr_o and cfg_data_o are held stable.
  - cfg_v_o never drops without a completing handshake.
- Per-core write states, in order (address / data):
  - e_freeze: FREEZE / 1
  - e_core_id: CORE_ID / core_cnt
  - e_icache_id: ICACHE_ID / 2*core_cnt
  - e_dcache_id: DCACHE_ID / 2*core_cnt+1
  - e_cce_id: CCE_ID / core_cnt
  - e_cce_mode_unc: CCE_MODE / e_cce_mode_uncached
- Microcode loop
  - e_ucode_fetch: cfg_v_o=0, rom_v_o=1, rom_addr_o=instr_cnt. Moves unconditionally to e_ucode_send.
  - The ROM has 1-cycle read latency. Its data holds until the next rom_v_o.
  - e_ucode_send: cfg_v_o=1, addr=UCODE_BASE+instr_cnt, data=rom_data_i.
  - On handshake: if instr_cnt==num_cce_instr_ram_els_p-1, clear instr_cnt and go to e_cce_mode_norm; otherwise increment instr_cnt and go to e_ucode_fetch.
  - Throughput is at most one microcode word per 2 cycles.
- Per-core closing states
  - e_cce_mode_norm: CCE_MODE / e_cce_mode_normal
  - e_unfreeze: FREEZE / 0
  - On the e_unfreeze handshake:
    - if core_cnt==num_core_p-1: go to e_done;
    - otherwise: core_cnt+1, then e_freeze.
- e_done: done_o=1, cfg_v_o=0. The block stays here until reset.
- Width rules
  - IDs are zero-extended to cfg_data_width_p.
  - UCODE_BASE+instr_cnt never carries out of cfg_addr_width_p.
  - clog2 widths use safe clog2, so the minimum width is 1.
- Total handshakes = num_core_p*(8+num_cce_instr_ram_els_p).

Optional Feature:
- Macro: BP_CFG_LOADER_STATS_EN.
- Defined:
  - Adds output stall_cnt_o, 32 bits, reset to 0.
  - It increments every cycle with cfg_v_o & ~cfg_ready_i and saturates at 32'hFFFF_FFFF.
  - It freezes once done_o=1.
- Undefined: no port and no counter logic. Bus behaviour is identical either way.

Decomposition:
- bp_common_cfg_pkg holds:
  - config address constants: FREEZE=16'h0001, CORE_ID=16'h0002, ICACHE_ID=16'h0003, DCACHE_ID=16'h0004, CCE_ID=16'h0005, CCE_MODE=16'h0006, UCODE_BASE=16'h8000;
  - enum bp_cce_mode_e {e_cce_mode_uncached=0, e_cce_mode_normal=1};
  - the loader state enum bp_cfg_loader_state_e.
- Natural sub-module: bp_cfg_loader_counter, a parameterised clear/increment/limit counter. It is instantiated for core_cnt and instr_cnt; the FSM stays in the top module.

Test Plan:
- num_core_p=1, els=4, cfg_ready_i=1 constantly:
  - 12 writes in program order; microcode at 0x8000..0x8003 with data = ROM words;
  - done_o rises within 20 cycles of reset release.
- num_core_p=2, els=4:
  - core 1 writes CORE_ID=1, ICACHE_ID=2, DCACHE_ID=3, CCE_ID=1, all with cfg_core_o=1;
  - exactly 24 handshakes in total.
- Random cfg_ready_i at 30%:
  - cfg_addr_o, cfg_data_o and cfg_core_o stay constant while cfg_v_o & ~cfg_ready_i;
  - write sequence identical to the ready=1 run.
- reset_n_i pulled low during the microcode word at 0x8002 of core 0:
  - all outputs 0 next cycle;
  - after release the first write is FREEZE/1 to core 0.
- cfg_ready_i=0 for 100 cycles after the first valid:
  - no progress;
  - with BP_CFG_LOADER_STATS_EN, stall_cnt_o=100 at the handshake.
- After done_o=1:
  - 50 further cycles show cfg_v_o=0, rom_v_o=0, done_o=1.
